// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core pipeline: default widths, the MEM/WB
// payload record and the state encoding used by the stage buffers.
package cpu_pkg;

    localparam int unsigned DEF_XLEN       = 32;
    localparam int unsigned DEF_REG_ADDR_W = 5;

    typedef struct packed {
        logic [DEF_XLEN-1:0]       pc;
        logic                      wb_en;
        logic                      mem_r_en;
        logic [DEF_XLEN-1:0]       alu_result;
        logic [DEF_XLEN-1:0]       mem_data;
        logic [DEF_REG_ADDR_W-1:0] dest;
    } mem_wb_payload_t;

    localparam int unsigned MEM_WB_PAYLOAD_W = $bits(mem_wb_payload_t);

    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        SB_EMPTY = 2'd0,
        SB_ONE   = 2'd1,
        SB_FULL  = 2'd2
    } skid_state_e;

    function automatic int unsigned payload_width(input int unsigned xlen,
                                                  input int unsigned reg_addr_w);
        return 3 * xlen + reg_addr_w + 2;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready stage buffer with flush; SKID=0 collapses it
// to a single register whose in_ready looks through to out_ready.
//
// state    | meaning
// ---------+-----------------------------------------------
// SB_EMPTY | nothing held, out_valid low
// SB_ONE   | head register valid, skid register free
// SB_FULL  | head and skid valid, in_ready low (SKID=1 only)
module pipe_skid_buf
    import cpu_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter bit          SKID = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] h_q, h_d;
    logic [W-1:0] s_q, s_d;
    logic         accept;
    logic         pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SB_EMPTY;
            h_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            s_q     <= s_d;
        end
    end

    always_comb begin
        accept  = in_valid & in_ready;
        pop     = out_valid & out_ready;
        state_d = state_q;
        h_d     = h_q;
        s_d     = s_q;
        case (state_q)
            SB_EMPTY: begin
                if (accept) begin
                    h_d     = in_data;
                    state_d = SB_ONE;
                end
            end
            SB_ONE: begin
                if (accept && pop) begin
                    h_d = in_data;
                end else if (accept && SKID) begin
                    s_d     = in_data;
                    state_d = SB_FULL;
                end else if (pop) begin
                    state_d = SB_EMPTY;
                end
            end
            SB_FULL: begin
                // Skid entry always moves into the head before anything newer arrives.
                if (pop) begin
                    h_d     = s_q;
                    state_d = SB_ONE;
                end
            end
            default: state_d = SB_EMPTY;
        endcase
        // Payload may be left stale; only the valid state is cleared.
        if (flush) begin
            state_d = SB_EMPTY;
        end
    end

    always_comb begin
        out_valid = (state_q != SB_EMPTY);
        occupancy = state_q;
        out_data  = h_q;
        if (SKID) begin
            in_ready = (state_q != SB_FULL);
        end else begin
            in_ready = out_ready | (state_q == SB_EMPTY);
        end
    end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline stage: buffers the MEM result with valid/ready flow control
// and presents the write-back value and gated write enable to the register file.
module mem_wb_pipe_reg
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN       = DEF_XLEN,
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter bit          SKID       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic                  in_wb_en,
    input  logic                  in_mem_r_en,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic [XLEN-1:0]       in_mem_data,
    input  logic [REG_ADDR_W-1:0] in_dest,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic                  out_wb_en,
    output logic                  out_mem_r_en,
    output logic [XLEN-1:0]       out_alu_result,
    output logic [XLEN-1:0]       out_mem_data,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic [XLEN-1:0]       out_wb_data,
    output logic [1:0]            occupancy
);

    localparam int unsigned PAYLOAD_W = payload_width(XLEN, REG_ADDR_W);

    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 head_wb_en;

    assign in_payload = {in_pc, in_wb_en, in_mem_r_en, in_alu_result, in_mem_data, in_dest};

    pipe_skid_buf #(
        .W    (PAYLOAD_W),
        .SKID (SKID)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload),
        .occupancy (occupancy)
    );

    assign {out_pc, head_wb_en, out_mem_r_en, out_alu_result, out_mem_data, out_dest} = out_payload;

    // A bubble or flushed head must never write the register file or feed forwarding.
    assign out_wb_en   = head_wb_en & out_valid;
    assign out_wb_data = out_mem_r_en ? out_mem_data : out_alu_result;

endmodule
